// File: rtl/ntr_responder.sv
// Host-clocked byte responder: synchronizes ntr_clk, detects its rising edges and
// shifts a captured 64-bit payload out LSB first, one byte per host rise.
module ntr_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NBYTES      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ntr_clk,
  input  logic        load,
  input  logic [63:0] word,
  output logic [7:0]  ntr_data_out,
  output logic        ntr_data_oe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(NBYTES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   rise_r;

  state_t      state_r;
  state_t      state_s;
  logic [63:0] shift_r;
  logic [63:0] shift_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_s;
  logic [7:0]  data_s;
  logic        oe_s;
  logic        busy_s;
  logic        done_s;

  // Synchronizer, history flop and registered one-cycle rise pulse; preset high so reset never fakes a rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '1;
      hist_r <= 1'b1;
      rise_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ntr_clk};
      hist_r <= sync_r[SYNC_STAGES-1];
      rise_r <= sync_r[SYNC_STAGES-1] & ~hist_r;
    end
  end

  // Next-state, shift/counter update and next output values
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (load) begin
          shift_s = word;
          cnt_s   = 3'd0;
          state_s = DRIVE;
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        if (rise_r) begin
          if (cnt_r == LAST_CNT) begin
            state_s = FINISH;
          end else begin
            shift_s = {8'h00, shift_r[63:8]};
            cnt_s   = cnt_r + 3'd1;
          end
        end else begin
          state_s = DRIVE;
        end
      end
      FINISH: begin
        shift_s = 64'h0;
        cnt_s   = 3'd0;
        state_s = IDLE;
      end
      default: begin
        shift_s = 64'h0;
        cnt_s   = 3'd0;
        state_s = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it at the edge
    data_s = 8'h00;
    oe_s   = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    if (state_s == DRIVE) begin
      data_s = shift_s[7:0];
      oe_s   = 1'b1;
      busy_s = 1'b1;
    end else begin
      done_s = (state_s == FINISH);
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= 64'h0;
      cnt_r        <= 3'd0;
      ntr_data_out <= 8'h00;
      ntr_data_oe  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      cnt_r        <= cnt_s;
      ntr_data_out <= data_s;
      ntr_data_oe  <= oe_s;
      busy         <= busy_s;
      done         <= done_s;
    end
  end

endmodule

// File: tb/tb_ntr_responder.sv
// Directed + randomized bench for ntr_responder: expected bytes come from word >> 8k,
// with a host rise taking exactly 4 clk edges (2 sync stages) to reach ntr_data_out.
module tb_ntr_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ntr_clk;
  logic        load;
  logic        load1;
  logic [63:0] word;
  logic [63:0] word1;
  logic [7:0]  data;
  logic        oe;
  logic        busy;
  logic        done;
  logic [7:0]  data1;
  logic        oe1;
  logic        busy1;
  logic        done1;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int done1_cnt   = 0;
  int exp_done    = 0;

  localparam int NB = 8;

  ntr_responder #(.SYNC_STAGES(2), .NBYTES(8)) dut (
    .clk(clk), .rst(rst), .ntr_clk(ntr_clk), .load(load), .word(word),
    .ntr_data_out(data), .ntr_data_oe(oe), .busy(busy), .done(done)
  );

  ntr_responder #(.SYNC_STAGES(2), .NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .ntr_clk(ntr_clk), .load(load1), .word(word1),
    .ntr_data_out(data1), .ntr_data_oe(oe1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (done1 === 1'b1) done1_cnt <= done1_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_data"}, {56'h0, data}, 64'h0);
    chk({tag, "_oe"}, {63'h0, oe}, 64'h0);
    chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
    chk({tag, "_done"}, {63'h0, done}, 64'h0);
  endtask

  // One transfer on the 8-byte instance; ntr_clk is expected low on entry and is low on exit
  task automatic run_transfer(input logic [63:0] w, input int start_high,
                              input int busy_load_at, input int abort_at, input int fixed_lo);
    logic [7:0] exp_b;
    int lo;
    if (start_high != 0) begin
      ntr_clk = 1'b1;
      repeat (5) tick();
    end
    load = 1'b1;
    word = w;
    tick();
    load = 1'b0;
    word = {$urandom, $urandom};
    chk("first_byte", {56'h0, data}, {56'h0, w[7:0]});
    chk("first_oe", {63'h0, oe}, 64'h1);
    chk("first_busy", {63'h0, busy}, 64'h1);
    if (start_high != 0) begin
      repeat ($urandom_range(3, 6)) begin
        tick();
        chk("held_high", {56'h0, data}, {56'h0, w[7:0]});
      end
      ntr_clk = 1'b0;
    end
    for (int k = 0; k < NB; k++) begin
      exp_b = 8'(w >> (8 * k));
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        repeat (6) begin
          tick();
          check_idle("abort_idle");
        end
        chk("abort_no_done", done_cnt, exp_done);
        return;
      end
      lo = (fixed_lo != 0) ? fixed_lo : $urandom_range(4, 9);
      load = (k == busy_load_at);
      word = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (lo) begin
        tick();
        load = 1'b0;
        chk("stable_lo", {56'h0, data}, {56'h0, exp_b});
        chk("stable_oe", {63'h0, oe}, 64'h1);
      end
      ntr_clk = 1'b1;
      repeat (3) begin
        tick();
        chk("pre_advance", {56'h0, data}, {56'h0, exp_b});
        chk("pre_busy", {63'h0, busy}, 64'h1);
      end
      tick();
      if (k < NB - 1) begin
        chk("advance", {56'h0, data}, {56'h0, 8'(w >> (8 * (k + 1)))});
        chk("advance_oe", {63'h0, oe}, 64'h1);
      end else begin
        chk("finish_done", {63'h0, done}, 64'h1);
        chk("finish_oe", {63'h0, oe}, 64'h0);
        chk("finish_busy", {63'h0, busy}, 64'h0);
        chk("finish_data", {56'h0, data}, 64'h0);
        exp_done++;
        tick();
        check_idle("after_finish");
      end
      ntr_clk = 1'b0;
    end
    tick();
    chk("done_count", done_cnt, exp_done);
  endtask

  initial begin
    rst     = 1'b1;
    ntr_clk = 1'b1;
    load    = 1'b0;
    load1   = 1'b0;
    word    = 64'h0;
    word1   = 64'h0;
    repeat (3) tick();
    check_idle("reset");
    chk("reset1_oe", {63'h0, oe1}, 64'h0);
    chk("reset1_done", {63'h0, done1}, 64'h0);
    rst = 1'b0;

    // ntr_clk high through reset release must not produce a byte or a done
    repeat (5) begin
      tick();
      check_idle("post_reset");
    end
    ntr_clk = 1'b0;
    repeat (4) tick();

    run_transfer(64'h0807060504030201, 0, -1, -1, 4);
    run_transfer({$urandom, $urandom}, 0, 3, -1, 0);
    run_transfer({$urandom, $urandom}, 1, -1, -1, 0);
    run_transfer(64'h0807060504030201, 0, -1, 2, 4);
    run_transfer(64'h00000000000000AA, 0, -1, -1, 0);
    repeat (4) run_transfer({$urandom, $urandom}, 0, -1, -1, 0);

    // Host clock activity with no load must leave both instances idle
    for (int c = 0; c < 20; c++) begin
      ntr_clk = 1'b1;
      repeat (4) begin
        tick();
        check_idle("idle_edges");
        chk("idle_edges_oe1", {63'h0, oe1}, 64'h0);
      end
      ntr_clk = 1'b0;
      repeat (4) tick();
    end
    chk("idle_done_count", done_cnt, exp_done);

    // Single-byte instance: one host rise goes straight to FINISH
    load1 = 1'b1;
    word1 = 64'h000000000000005A;
    tick();
    load1 = 1'b0;
    chk("nb1_data", {56'h0, data1}, 64'h5A);
    chk("nb1_oe", {63'h0, oe1}, 64'h1);
    repeat (4) tick();
    chk("nb1_hold", {56'h0, data1}, 64'h5A);
    ntr_clk = 1'b1;
    repeat (3) begin
      tick();
      chk("nb1_pre", {56'h0, data1}, 64'h5A);
    end
    tick();
    chk("nb1_done", {63'h0, done1}, 64'h1);
    chk("nb1_oe_off", {63'h0, oe1}, 64'h0);
    chk("nb1_data_off", {56'h0, data1}, 64'h0);
    tick();
    chk("nb1_done_pulse", {63'h0, done1}, 64'h0);
    chk("nb1_busy_after", {63'h0, busy1}, 64'h0);
    ntr_clk = 1'b0;
    repeat (3) tick();
    chk("nb1_done_count", done1_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
